// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
//   Shared definitions for the HD44780-style 4-bit LCD interface:
//   - transmitter state encoding
//   - common command bytes used by the init sequencer and DDRAM writers
//   - default controller timing (cycles at 50 MHz)
//   - helpers used to pick the post-byte execution wait and size counters
// ---------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET_H  = 3'd1,
        ST_EN_H   = 3'd2,
        ST_HOLD_H = 3'd3,
        ST_SET_L  = 3'd4,
        ST_EN_L   = 3'd5,
        ST_HOLD_L = 3'd6,
        ST_WAIT   = 3'd7
    } lcd_state_e;

    // Controller command bytes.
    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;
    localparam logic [7:0] LCD_DDRAM = 8'h80;
    localparam logic [6:0] LCD_LINE2 = 7'h40;
    localparam logic [7:0] LCD_FUNC4 = 8'h28;

    // Default timing in clk cycles (50 MHz).
    localparam int T_SETUP_DEF = 2;
    localparam int T_EPW_DEF   = 25;
    localparam int T_HOLD_DEF  = 2;
    localparam int T_CMD_DEF   = 2000;   // ~40 us
    localparam int T_CLEAR_DEF = 82000;  // ~1.64 ms

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    // 0x00 is not a real command and takes the normal wait.
    function automatic logic needs_long_wait(input logic       rs,
                                             input logic       nib,
                                             input logic [7:0] data);
        return !rs && !nib && (data[7:2] == 6'd0) && (data != 8'h00);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// ---------------------------------------------------------------------------
// lcd_delay_counter
//   Loadable down-counter with terminal-count flag. Loading N-1 on entry to a
//   timed state gives exactly N cycles before zero is seen.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset (count -> 0)
//   load      in   load load_val this cycle (takes priority over decrement)
//   load_val  in   value loaded
//   zero      out  count is 0 (terminal count)
// ---------------------------------------------------------------------------
module lcd_delay_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_nibble_tx.sv
// ---------------------------------------------------------------------------
// lcd_nibble_tx
//   Physical-layer transmitter for an HD44780-style LCD in 4-bit mode. Takes
//   one byte per valid/ready handshake and sends it as two nibbles (or just
//   the high nibble when req_nib=1), each framed by setup / enable / hold
//   timing, followed by the controller execution wait.
//
// Ports:
//   clk        in   clock (rising edge)
//   reset      in   synchronous active-high reset
//   req_valid  in   request present, req_* stable until accepted
//   req_ready  out  idle, request accepted when req_valid & req_ready
//   req_rs     in   0 = command, 1 = data
//   req_nib    in   send only req_data[7:4]
//   req_data   in   byte to send
//   done       out  one-cycle pulse when a transfer and its wait complete
//   rs         out  LCD register select
//   rw         out  LCD read/write, always write (0)
//   e          out  LCD enable
//   lcd_data   out  LCD D7..D4
//
// State   | Meaning
// --------+--------------------------------------------------------------
// IDLE    | req_ready=1, waiting for a request
// SET_H   | high nibble on bus, setup before e rises (T_SETUP)
// EN_H    | e high for high nibble (T_EPW)
// HOLD_H  | e low, high nibble held (T_HOLD)
// SET_L   | low nibble on bus, setup before e rises (T_SETUP)
// EN_L    | e high for low nibble (T_EPW)
// HOLD_L  | e low, low nibble held (T_HOLD)
// WAIT    | controller execution time (T_CMD or T_CLEAR)
// ---------------------------------------------------------------------------
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_EPW   = T_EPW_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_CMD   = T_CMD_DEF,
    parameter int T_CLEAR = T_CLEAR_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic       req_nib,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       rs,
    output logic       rw,
    output logic       e,
    output logic [3:0] lcd_data
);

    localparam int CW = $clog2(max3(T_CLEAR, T_CMD, T_EPW)) + 1;

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EPW   = CW'(T_EPW - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD - 1);
    localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR - 1);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_SET_H  = ST_SET_H;
    localparam logic [2:0] S_EN_H   = ST_EN_H;
    localparam logic [2:0] S_HOLD_H = ST_HOLD_H;
    localparam logic [2:0] S_SET_L  = ST_SET_L;
    localparam logic [2:0] S_EN_L   = ST_EN_L;
    localparam logic [2:0] S_HOLD_L = ST_HOLD_L;
    localparam logic [2:0] S_WAIT   = ST_WAIT;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic          nib_q;
    logic [7:0]    data_q;
    logic          accept;
    logic          tmr_zero;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic [CW-1:0] wait_val;

    assign rw     = 1'b0;
    assign accept = req_valid && req_ready;

    // rs already holds the latched request select for the whole transfer.
    assign wait_val = needs_long_wait(rs, nib_q, data_q) ? LD_CLEAR : LD_CMD;

    // Every timed state exits to a different state, so a state change is
    // exactly the cycle the timer must be reloaded for the next state.
    always_comb begin
        state_next = state;
        tmr_val    = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_SET_H;
                    tmr_val    = LD_SETUP;
                end
            end
            S_SET_H: begin
                if (tmr_zero) begin
                    state_next = S_EN_H;
                    tmr_val    = LD_EPW;
                end
            end
            S_EN_H: begin
                if (tmr_zero) begin
                    state_next = S_HOLD_H;
                    tmr_val    = LD_HOLD;
                end
            end
            S_HOLD_H: begin
                if (tmr_zero) begin
                    if (nib_q) begin
                        state_next = S_WAIT;
                        tmr_val    = wait_val;
                    end else begin
                        state_next = S_SET_L;
                        tmr_val    = LD_SETUP;
                    end
                end
            end
            S_SET_L: begin
                if (tmr_zero) begin
                    state_next = S_EN_L;
                    tmr_val    = LD_EPW;
                end
            end
            S_EN_L: begin
                if (tmr_zero) begin
                    state_next = S_HOLD_L;
                    tmr_val    = LD_HOLD;
                end
            end
            S_HOLD_L: begin
                if (tmr_zero) begin
                    state_next = S_WAIT;
                    tmr_val    = wait_val;
                end
            end
            S_WAIT: begin
                if (tmr_zero) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign tmr_load = (state_next != state);

    lcd_delay_counter #(
        .WIDTH (CW)
    ) u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Outputs are updated only on state transitions so that rs/lcd_data
    // change only while e is low and e-high runs are exactly one EN state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            done      <= 1'b0;
            rs        <= 1'b0;
            e         <= 1'b0;
            lcd_data  <= 4'h0;
            nib_q     <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        rs        <= req_rs;
                        nib_q     <= req_nib;
                        data_q    <= req_data;
                        lcd_data  <= req_data[7:4];
                    end
                end
                S_SET_H, S_SET_L: begin
                    if (tmr_zero) e <= 1'b1;
                end
                S_EN_H, S_EN_L: begin
                    if (tmr_zero) e <= 1'b0;
                end
                S_HOLD_H: begin
                    if (tmr_zero && !nib_q) lcd_data <= data_q[3:0];
                end
                S_WAIT: begin
                    if (tmr_zero) begin
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    e <= 1'b0;
                end
            endcase
        end
    end

endmodule
